// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan display.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_pkg;

  // Number of scanned digit slots per frame.
  localparam int NUM_SCAN = 4;

  // Active-low pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; element [k] is the glyph for digit k.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to active-low seven-segment pattern; non-decimal codes go dark.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  // Table lookup for 0-9, everything else blank.
  always_comb begin
    seg_o = SEG_BLANK;
    if (val_i <= 4'd9) begin
      seg_o = SEG_DIGITS[val_i];
    end
  end

endmodule

// File: rtl/sum_display_scan.sv
// Latches A, B and their sum and scans them onto a 4-slot multiplexed 7-seg display.
// Latency: new values appear from the next frame boundary; outputs are registered (1 cycle).
// Backpressure: none; the last load before a frame boundary wins.
module sum_display_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       load,
  input  logic [1:0] a_in,
  input  logic [1:0] b_in,
  input  logic [2:0] sum_in,
  input  logic       blank,
  output logic [7:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PCNT_SHOW = PW'(BLANK_CYCLES);
  localparam logic [1:0]    DIG_LAST  = 2'(NUM_SCAN - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    dig_q, dig_d;
  logic          blank_q, blank_d;
  logic [1:0]    pa_q, pa_d, pb_q, pb_d, da_q, da_d, db_q, db_d;
  logic [2:0]    ps_q, ps_d, ds_q, ds_d;
  logic          pend_v_q, pend_v_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;
  logic [3:0]    slot_val;
  logic [6:0]    dec_seg;
  logic          slot_end, frame_end;

  assign slot_end  = (pcnt_q == PCNT_LAST);
  assign frame_end = slot_end && (dig_q == DIG_LAST);

  // Prescaler, digit index, and per-slot sampling of the blank request.
  always_comb begin
    pcnt_d  = pcnt_q + PW'(1);
    dig_d   = dig_q;
    blank_d = blank_q;
    if (slot_end) begin
      pcnt_d  = '0;
      dig_d   = dig_q + 2'd1;
      blank_d = blank;
    end
  end

  // Load capture into the pending set and transfer to the shown set at frame end.
  always_comb begin
    pa_d     = pa_q;
    pb_d     = pb_q;
    ps_d     = ps_q;
    pend_v_d = pend_v_q;
    da_d     = da_q;
    db_d     = db_q;
    ds_d     = ds_q;
    if (load) begin
      pa_d     = a_in;
      pb_d     = b_in;
      ps_d     = sum_in;
      pend_v_d = 1'b1;
    end
    if (frame_end) begin
      pend_v_d = 1'b0;
      if (load) begin
        da_d = a_in;
        db_d = b_in;
        ds_d = sum_in;
      end else if (pend_v_q) begin
        da_d = pa_q;
        db_d = pb_q;
        ds_d = ps_q;
      end
    end
  end

  // Pick the value for the current slot; the unused slot decodes to dark.
  always_comb begin
    case (dig_q)
      2'd0:    slot_val = {1'b0, ds_q};
      2'd2:    slot_val = {2'b00, db_q};
      2'd3:    slot_val = {2'b00, da_q};
      default: slot_val = 4'hF;
    endcase
  end

  seg7_decode u_decode (
    .val_i (slot_val),
    .seg_o (dec_seg)
  );

  // Next output values: dark during the blanking head of a slot, one anode low after.
  always_comb begin
    an_d    = 4'hF;
    seg_d   = SEG_BLANK;
    frame_d = (pcnt_d == PCNT_LAST) && (dig_d == DIG_LAST);
    if (pcnt_q >= PCNT_SHOW) begin
      seg_d = dec_seg;
      if (!blank_q && (dig_q != 2'd1)) begin
        an_d[dig_q] = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pcnt_q   <= '0;
      dig_q    <= 2'd0;
      blank_q  <= 1'b0;
      pa_q     <= 2'd0;
      pb_q     <= 2'd0;
      ps_q     <= 3'd0;
      pend_v_q <= 1'b0;
      da_q     <= 2'd0;
      db_q     <= 2'd0;
      ds_q     <= 3'd0;
      an_q     <= 4'hF;
      seg_q    <= SEG_BLANK;
      frame_q  <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      dig_q    <= dig_d;
      blank_q  <= blank_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      ps_q     <= ps_d;
      pend_v_q <= pend_v_d;
      da_q     <= da_d;
      db_q     <= db_d;
      ds_q     <= ds_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign AN    = {4'hF, an_q};
  assign SEG   = seg_q;
  assign DP    = 1'b1;
  assign frame = frame_q;

endmodule

// File: tb/tb_sum_display_scan.sv
// Bench for sum_display_scan: directed scenarios plus random loads/blank toggles.
// A cycle-level reference model pushes expected outputs; a monitor pops and compares.
module tb_sum_display_scan;

  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FR  = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       blank = 1'b0;
  logic [1:0] a_in = 2'd0;
  logic [1:0] b_in = 2'd0;
  logic [2:0] sum_in = 3'd0;
  logic [7:0] AN;
  logic [6:0] SEG;
  logic       DP;
  logic       frame;

  always #5 clk = ~clk;

  sum_display_scan #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .load       (load),
    .a_in       (a_in),
    .b_in       (b_in),
    .sum_in     (sum_in),
    .blank      (blank),
    .AN         (AN),
    .SEG        (SEG),
    .DP         (DP),
    .frame      (frame)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       seg_chk;
    logic       frm;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int s;
  } ld_t;

  exp_t sbq[$];
  ld_t  pend[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: edges since reset release, values on display, sampled blank.
  int p = 0;
  int sh_a = 0, sh_b = 0, sh_s = 0;
  int blank_m = 0;

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Model: on each edge predict the registered outputs, then apply load/frame/blank rules.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        p = 0; sh_a = 0; sh_b = 0; sh_s = 0; blank_m = 0;
        pend.delete();
        sbq.delete();
      end else begin
        exp_t e;
        ld_t  l;
        int   pc, dg, v;
        pc = p % DIV;
        dg = (p / DIV) % 4;
        e.an = 8'hFF; e.seg = 7'h7F; e.seg_chk = 1'b1;
        if (pc >= BLK) begin
          if (dg == 1 || blank_m != 0) begin
            e.seg_chk = 1'b0;
          end else begin
            e.an = 8'hFF ^ (8'h01 << dg);
            v = (dg == 0) ? sh_s : (dg == 2) ? sh_b : sh_a;
            e.seg = pat(v);
          end
        end
        l.a = int'(a_in); l.b = int'(b_in); l.s = int'(sum_in);
        if (p % FR == FR - 1) begin
          if (load) begin
            sh_a = l.a; sh_b = l.b; sh_s = l.s;
          end else if (pend.size() > 0) begin
            sh_a = pend[$].a; sh_b = pend[$].b; sh_s = pend[$].s;
          end
          pend.delete();
        end else if (load) begin
          pend.push_back(l);
        end
        if (pc == DIV - 1) blank_m = int'(blank);
        p++;
        e.frm = (p % FR == FR - 1);
        sbq.push_back(e);
      end
    end
  end

  // Monitor: compare outputs at each falling edge against reset values or the queue head.
  initial begin
    forever begin
      @(negedge clk);
      chk("dp", int'(DP), 1);
      if (!rst_n) begin
        chk("rst_an", int'(AN), 8'hFF);
        chk("rst_seg", int'(SEG), 7'h7F);
        chk("rst_frame", int'(frame), 0);
      end else if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("an", int'(AN), int'(e.an));
        chk("frame", int'(frame), int'(e.frm));
        if (e.seg_chk) chk("seg", int'(SEG), int'(e.seg));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_phase(input int ph);
    for (int i = 0; i < FR + 1; i++) begin
      if (p % FR == ph) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL to_phase timeout actual=%0d required=%0d", p % FR, ph);
  endtask

  task automatic do_load(input int a, input int b, input int s);
    a_in = 2'(a); b_in = 2'(b); sum_in = 3'(s);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Stimulus: directed scenarios first, then a random soak.
  initial begin
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(FR + 4);

    // Mid-frame load: visible only from the next frame.
    to_phase(12);
    do_load(3, 2, 5);
    step(2 * FR);

    // Load on the boundary cycle: visible in the very next slot 0.
    to_phase(FR - 1);
    do_load(1, 1, 2);
    step(FR);

    // Two loads in one frame: the second wins, the first never shows.
    to_phase(5);
    do_load(0, 0, 1);
    to_phase(20);
    do_load(0, 0, 6);
    step(2 * FR);

    // Blank raised mid-slot, later dropped.
    to_phase(13);
    blank = 1'b1;
    step(20);
    blank = 1'b0;
    step(2 * FR);

    // Asynchronous reset during a SHOW phase.
    to_phase(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an", int'(AN), 8'hFF);
    chk("async_seg", int'(SEG), 7'h7F);
    chk("async_frame", int'(frame), 0);
    step(2);
    rst_n = 1'b1;
    step(2 * FR);

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      a_in   = 2'($urandom_range(0, 3));
      b_in   = 2'($urandom_range(0, 3));
      sum_in = 3'($urandom_range(0, 7));
      load   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) blank = ~blank;
      @(negedge clk);
    end
    load = 1'b0;
    blank = 1'b0;
    step(2 * FR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
